// File: rtl/basic_system_rst_switch_ctrl.sv
// Reset-switch controller: synchronizes and debounces a pushbutton, issues a
// fixed-width reset request pulse, and exposes an Avalon-MM register file.
module basic_system_rst_switch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 16,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        reset_req,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DB_PRESS   = 3'd1,
        S_PULSE      = 3'd2,
        S_HELD       = 3'd3,
        S_DB_RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  PL_LAST = 8'(PULSE_CYCLES - 1);

    logic        r_sync1, r_sync2;
    state_t      r_state, w_nxt_state;
    logic [15:0] r_db_cnt, w_nxt_db_cnt;
    logic [7:0]  r_pl_cnt, w_nxt_pl_cnt;
    logic        r_reset_req;
    logic        r_debounced;
    logic        r_edge_cap;
    logic [7:0]  r_press_cnt;
    logic [1:0]  r_ctrl;
    logic        w_pressed;
    logic        w_press_ev;
    logic        w_release_ev;
    logic        w_wr;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign w_unused  = &{1'b0, writedata[31:2]};
    assign w_pressed = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_wr      = chipselect & ~write_n;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_db_cnt = r_db_cnt;
        w_nxt_pl_cnt = r_pl_cnt;
        w_press_ev   = 1'b0;
        w_release_ev = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pressed) begin
                    w_nxt_state  = S_DB_PRESS;
                    w_nxt_db_cnt = '0;
                end
            end
            S_DB_PRESS: begin
                if (!w_pressed) begin
                    w_nxt_state = S_IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_press_ev   = 1'b1;
                    w_nxt_pl_cnt = '0;
                    w_nxt_state  = r_ctrl[0] ? S_PULSE : S_HELD;
                end else begin
                    w_nxt_db_cnt = r_db_cnt + 16'd1;
                end
            end
            // The switch level is deliberately ignored so the pulse always completes.
            S_PULSE: begin
                if (r_pl_cnt == PL_LAST) begin
                    w_nxt_state = S_HELD;
                end else begin
                    w_nxt_pl_cnt = r_pl_cnt + 8'd1;
                end
            end
            S_HELD: begin
                if (!w_pressed) begin
                    w_nxt_state  = S_DB_RELEASE;
                    w_nxt_db_cnt = '0;
                end
            end
            S_DB_RELEASE: begin
                if (w_pressed) begin
                    w_nxt_state = S_HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_release_ev = 1'b1;
                    w_nxt_state  = S_IDLE;
                end else begin
                    w_nxt_db_cnt = r_db_cnt + 16'd1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0: w_rd_mux[0]    = r_debounced;
            2'd1: w_rd_mux[1:0]  = r_ctrl;
            2'd2: w_rd_mux[0]    = r_edge_cap;
            2'd3: w_rd_mux[15:0] = {r_press_cnt, 4'b0, r_state, r_reset_req};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_pl_cnt    <= '0;
            r_reset_req <= 1'b0;
            r_debounced <= 1'b0;
            r_edge_cap  <= 1'b0;
            r_press_cnt <= '0;
            r_ctrl      <= 2'b01;
            readdata    <= '0;
        end else begin
            r_sync1     <= in_port;
            r_sync2     <= r_sync1;
            r_state     <= w_nxt_state;
            r_db_cnt    <= w_nxt_db_cnt;
            r_pl_cnt    <= w_nxt_pl_cnt;
            // Registered so the pulse tracks the PULSE state cycle-for-cycle.
            r_reset_req <= (w_nxt_state == S_PULSE);
            readdata    <= w_rd_mux;
            if (w_press_ev) begin
                r_debounced <= 1'b1;
                r_press_cnt <= r_press_cnt + 8'd1;
            end else if (w_release_ev) begin
                r_debounced <= 1'b0;
            end
            if (w_wr && address == 2'd1) begin
                r_ctrl <= writedata[1:0];
            end
            // A press event in the same cycle as a W1C clear keeps the flag set.
            if (w_press_ev) begin
                r_edge_cap <= 1'b1;
            end else if (w_wr && address == 2'd2 && writedata[0]) begin
                r_edge_cap <= 1'b0;
            end
        end
    end

    assign reset_req = r_reset_req;
    assign irq       = r_ctrl[1] & r_edge_cap;

endmodule

// File: doc/basic_system_rst_switch_ctrl.md
BASIC_SYSTEM_RST_SWITCH_CTRL -- requirements
Module: basic_system_rst_switch_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 50000, number of stable synchronized samples needed to accept a switch level change (range 2..65535).
REQ-002 Parameter: PULSE_CYCLES, 16, width in clk cycles of the reset_req pulse (range 1..255).
REQ-003 Parameter: ACTIVE_LOW, 1, 1 = switch pressed when in_port is 0; 0 = pressed when in_port is 1.
REQ-004 Port: clk  input  1  single system clock; every flop is clocked on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: address  input  2  Avalon-MM word address.
REQ-007 Port: chipselect  input  1  Avalon-MM slave select.
REQ-008 Port: write_n  input  1  Avalon-MM write strobe, active-low, qualified by chipselect.
REQ-009 Port: writedata  input  32  Avalon-MM write data.
REQ-010 Port: readdata  output  32  Avalon-MM registered read data.
REQ-011 Port: in_port  input  1  raw, asynchronous reset-switch level.
REQ-012 Port: reset_req  output  1  registered, active-high reset-request pulse to the system reset controller.
REQ-013 Port: irq  output  1  level-sensitive interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a 2-flop synchronizer; "pressed" is the synchronized level XOR (ACTIVE_LOW == 0 ? 0 : 1) applied as specified in REQ-003.
REQ-015 The FSM SHALL have the states IDLE, DB_PRESS, PULSE, HELD and DB_RELEASE, plus a 16-bit debounce counter and an 8-bit pulse counter.
REQ-016 IDLE: if pressed, go to DB_PRESS with the debounce counter cleared to 0; otherwise stay in IDLE.
REQ-017 DB_PRESS: if released, go to IDLE. If pressed and the counter is below DEBOUNCE_CYCLES-1, increment the counter.
REQ-018 DB_PRESS: if pressed and the counter equals DEBOUNCE_CYCLES-1, perform a press event: set debounced=1, set edge_cap=1, increment press_cnt, then go to PULSE if ctrl.auto_en=1, else go to HELD.
REQ-019 press_cnt SHALL be 8 bits wide and SHALL wrap from 255 to 0.
REQ-020 PULSE: reset_req SHALL be 1 for exactly PULSE_CYCLES consecutive cycles, starting the cycle after the press event; the FSM then goes to HELD. Release during PULSE SHALL NOT shorten the pulse.
REQ-021 HELD: when released, go to DB_RELEASE with the counter cleared to 0.
REQ-022 DB_RELEASE: if pressed, return to HELD. If released and the counter equals DEBOUNCE_CYCLES-1, set debounced=0 and go to IDLE; otherwise increment the counter.
REQ-023 reset_req SHALL be 0 in every state other than PULSE.
REQ-024 Register map (readdata[31:0]):
- addr 0, DATA, RO: bit0 = debounced.
- addr 1, CTRL, RW: bit0 = auto_en, bit1 = irq_en.
- addr 2, EDGE, RW1C: bit0 = edge_cap.
- addr 3, STATUS, RO: bit0 = reset_req, bits3:1 = FSM state code (IDLE=0, DB_PRESS=1, PULSE=2, HELD=3, DB_RELEASE=4), bits15:8 = press_cnt.
- All unlisted bits read 0.
REQ-025 readdata SHALL be registered every clk cycle from the address mux, independent of any read strobe, giving 1-cycle read latency.
REQ-026 A write occurs when chipselect=1 and write_n=0. Writes to addr 0 and addr 3 SHALL be ignored.
REQ-027 Writing 1 to EDGE bit0 SHALL clear edge_cap. If a press event occurs in the same cycle, the set SHALL win.
REQ-028 irq SHALL equal irq_en AND edge_cap, with no additional cycle of latency.
REQ-029 Changing auto_en SHALL take effect only at the next press event; a pulse already in progress SHALL complete.
REQ-030 The block SHALL use no combinational path from in_port to any output.

Reset
REQ-031 When reset_n=0, all of the following SHALL clear asynchronously to 0: state=IDLE, both counters, the synchronizer flops, debounced, edge_cap, press_cnt, readdata, reset_req.
REQ-032 On reset, CTRL SHALL reset to auto_en=1, irq_en=0.
REQ-033 Asserting reset_n mid-PULSE SHALL terminate the pulse immediately. After reset_n deasserts with the switch still held, a fresh debounce SHALL be required before any new event.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, ACTIVE_LOW=1)
REQ-034 Glitch: in_port low for 3 cycles, then high -> FSM returns to IDLE; DATA=0, edge_cap=0, press_cnt=0, reset_req stays 0.
REQ-035 Clean press, auto_en=1: in_port held low -> press event; reset_req high for exactly 3 cycles; DATA=1; STATUS[15:8]=1; in_port high for 4+ cycles -> DATA=0.
REQ-036 auto_en=0, irq_en=1: press -> reset_req never asserts; irq=1. Write 1 to addr 2 -> irq=0 on the next cycle.
REQ-037 A press event in the same cycle as a write of 1 to addr 2 -> edge_cap=1 and irq stays 1.
REQ-038 256 press/release cycles -> STATUS[15:8] wraps back to 0.
REQ-039 reset_n asserted on the 2nd pulse cycle -> reset_req=0 immediately; with in_port still low after release, a new pulse starts only after 2 synchronizer cycles plus 4 debounce cycles.
